divide32_request_sequencer: RTL and testbench

// - Upstream feeder and result collector for the 32/16 unsigned restoring divider.
// - Buffers division requests in a FIFO and issues them one at a time: one-cycle div_start pulse with stable operands.
// - Waits for the divider to finish, then holds quotient/remainder in a result register under a valid/ready handshake.

---
 rtl/divide32_request_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_divide32_request_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide32_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : divide32_request_sequencer
// Description : Request FIFO and result collector for a 32/16 unsigned
//               restoring divider. Issues one request at a time with a
//               single-cycle div_start, waits for the divider, then holds
//               quotient/remainder under a valid/ready handshake.
//               Optional macro DIV0_BYPASS_EN: zero-divisor requests are
//               answered locally without starting the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module divide32_request_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_dividend,
    input  logic [15:0]      req_divisor,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_quotient,
    output logic [15:0]      res_remainder,
    output logic             res_div0,
    output logic             div_start,
    output logic [31:0]      div_dividend,
    output logic [15:0]      div_divisor,
    input  logic [31:0]      div_quotient,
    input  logic [15:0]      div_remainder,
    input  logic             div_ready,
    input  logic             div_busy,
    output logic [PTR_W:0]   pending
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_WAIT    = 2'd1;
    localparam logic [1:0]       c_HOLD    = 2'd2;
    localparam logic [PTR_W:0]   c_FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    // FIFO storage and pointers
    logic [31:0]      fifo_dvd_q [DEPTH];
    logic [31:0]      fifo_dvd_d [DEPTH];
    logic [15:0]      fifo_dvs_q [DEPTH];
    logic [15:0]      fifo_dvs_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // Sequencer state
    logic [1:0]       state_q, state_d;
    logic             seen_busy_q, seen_busy_d;
    logic [31:0]      op_dvd_q, op_dvd_d;
    logic [15:0]      op_dvs_q, op_dvs_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_quo_q, res_quo_d;
    logic [15:0]      res_rem_q, res_rem_d;
`ifdef DIV0_BYPASS_EN
    logic             res_div0_q, res_div0_d;
`endif

    // Combinational control
    logic             w_push;
    logic             w_pop;
    logic             w_pop_issue;
    logic             w_pop_bypass;
    logic             w_capture;
    logic             w_res_accept;
    logic             w_fifo_empty;
    logic [31:0]      w_head_dvd;
    logic [15:0]      w_head_dvs;

    assign w_fifo_empty = (count_q == '0);
    assign w_head_dvd   = fifo_dvd_q[rd_ptr_q];
    assign w_head_dvs   = fifo_dvs_q[rd_ptr_q];
    // Readiness depends on stored occupancy only, so a pop in the same
    // cycle never opens room for a push into a full FIFO.
    assign req_ready    = reset & (count_q != c_FULL);
    assign w_push       = req_valid & req_ready;
    assign w_pop        = w_pop_issue | w_pop_bypass;

`ifdef DIV0_BYPASS_EN
    logic w_head_zero;
    assign w_head_zero = (w_head_dvs == 16'd0);
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one division in flight, result held until accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_pop_issue) begin
                    state_d = c_WAIT;
                end else if (w_pop_bypass) begin
                    state_d = c_HOLD;
                end
            end
            c_WAIT: begin
                if (w_capture) begin
                    state_d = c_HOLD;
                end
            end
            c_HOLD: begin
                if (w_res_accept) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // FSM outputs: pop/issue decision, capture and result acceptance strobes
    always_comb begin
        w_pop_issue  = 1'b0;
        w_pop_bypass = 1'b0;
        w_capture    = 1'b0;
        w_res_accept = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (reset && !w_fifo_empty) begin
`ifdef DIV0_BYPASS_EN
                    if (w_head_zero) begin
                        w_pop_bypass = 1'b1;
                    end else
`endif
                    if (!div_busy) begin
                        w_pop_issue = 1'b1;
                    end
                end
            end
            // A stale div_ready from a previous operation is ignored until
            // the divider has been seen busy on the current one.
            c_WAIT:  w_capture    = seen_busy_q & div_ready & ~div_busy;
            c_HOLD:  w_res_accept = res_ready;
            default: ;
        endcase
    end

    // Datapath next-state: FIFO, operand latch, busy tracker, result register
    always_comb begin
        fifo_dvd_d  = fifo_dvd_q;
        fifo_dvs_d  = fifo_dvs_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        op_dvd_d    = op_dvd_q;
        op_dvs_d    = op_dvs_q;
        seen_busy_d = seen_busy_q;
        res_valid_d = res_valid_q;
        res_quo_d   = res_quo_q;
        res_rem_d   = res_rem_q;
`ifdef DIV0_BYPASS_EN
        res_div0_d  = res_div0_q;
`endif
        if (w_push) begin
            fifo_dvd_d[wr_ptr_q] = req_dividend;
            fifo_dvs_d[wr_ptr_q] = req_divisor;
            wr_ptr_d             = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: ;
        endcase
        if (state_q == c_IDLE) begin
            seen_busy_d = 1'b0;
        end else if ((state_q == c_WAIT) && div_busy) begin
            seen_busy_d = 1'b1;
        end
        if (w_pop_issue) begin
            op_dvd_d = w_head_dvd;
            op_dvs_d = w_head_dvs;
        end
        if (w_capture) begin
            res_valid_d = 1'b1;
            res_quo_d   = div_quotient;
            res_rem_d   = div_remainder;
`ifdef DIV0_BYPASS_EN
            res_div0_d  = 1'b0;
`endif
        end
        if (w_pop_bypass) begin
            res_valid_d = 1'b1;
            res_quo_d   = 32'hFFFF_FFFF;
            res_rem_d   = w_head_dvd[15:0];
`ifdef DIV0_BYPASS_EN
            res_div0_d  = 1'b1;
`endif
        end
        if (w_res_accept) begin
            res_valid_d = 1'b0;
        end
    end

    // Datapath registers; reset flushes the FIFO and discards any result
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_dvd_q[i] <= '0;
                fifo_dvs_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            op_dvd_q    <= '0;
            op_dvs_q    <= '0;
            seen_busy_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_quo_q   <= '0;
            res_rem_q   <= '0;
`ifdef DIV0_BYPASS_EN
            res_div0_q  <= 1'b0;
`endif
        end else begin
            fifo_dvd_q  <= fifo_dvd_d;
            fifo_dvs_q  <= fifo_dvs_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            op_dvd_q    <= op_dvd_d;
            op_dvs_q    <= op_dvs_d;
            seen_busy_q <= seen_busy_d;
            res_valid_q <= res_valid_d;
            res_quo_q   <= res_quo_d;
            res_rem_q   <= res_rem_d;
`ifdef DIV0_BYPASS_EN
            res_div0_q  <= res_div0_d;
`endif
        end
    end

    // Operands come straight from the FIFO head in the start cycle, then
    // from the latch so they stay put until the result is accepted.
    assign div_start     = w_pop_issue;
    assign div_dividend  = w_pop_issue ? w_head_dvd : op_dvd_q;
    assign div_divisor   = w_pop_issue ? w_head_dvs : op_dvs_q;
    assign res_valid     = res_valid_q;
    assign res_quotient  = res_quo_q;
    assign res_remainder = res_rem_q;
    assign pending       = count_q;
`ifdef DIV0_BYPASS_EN
    assign res_div0      = res_div0_q;
`else
    assign res_div0      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_divide32_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_divide32_request_sequencer
// Description : Self-checking bench for divide32_request_sequencer with a
//               behavioural divider and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divide32_request_sequencer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_HOLD = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_dividend = '0;
    logic [15:0]      req_divisor = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_quotient;
    logic [15:0]      res_remainder;
    logic             res_div0;
    logic             div_start;
    logic [31:0]      div_dividend;
    logic [15:0]      div_divisor;
    logic [31:0]      div_quotient = '0;
    logic [15:0]      div_remainder = '0;
    logic             div_ready = 1'b0;
    logic             div_busy = 1'b0;
    logic [PTR_W:0]   pending;

    always #5 clock = ~clock;

    divide32_request_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_quotient(res_quotient), .res_remainder(res_remainder),
        .res_div0(res_div0),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_ready(div_ready), .div_busy(div_busy),
        .pending(pending)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus knobs
    logic        rst_drv   = 1'b0;
    int          valid_pct = 100;
    int          ready_pct = 100;
    int          lat_min   = 1;
    int          lat_max   = 4;
    int          gap_pct   = 0;
    int          start_cnt = 0;

    // Requests waiting to be offered, reference FIFO, accepted results
    logic [47:0] stim_q [$];
    logic [47:0] fifo_m [$];
    logic [48:0] log_q  [$];

    // Reference view of the request currently being served
    int          phase = PH_IDLE;
    logic [31:0] exp_q = '0;
    logic [15:0] exp_r = '0;
    logic        exp_d0 = 1'b0;
    logic [47:0] fl_op = '0;
    logic        fl_issued = 1'b0;

    // Behavioural divider state
    int          dv_delay = 0;
    int          dv_cnt = 0;
    logic [47:0] dv_op = '0;
    logic        dv_owner = 1'b0;

    function automatic logic [47:0] ref_div(input logic [47:0] op);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        a = op[47:16];
        b = {16'd0, op[15:0]};
        if (b == 32'd0) return {32'hFFFF_FFFF, a[15:0]};
        r = a % b;
        return {a / b, r[15:0]};
    endfunction

    // One clock cycle: drive inputs, advance the divider, check, update model
    task automatic cycle();
        logic        s_rdy, s_start, s_rv, exp_start, exp_bypass, exp_rdy, cap_now;
        logic [47:0] head, opnd;
        logic [48:0] res_now, res_exp;
        @(negedge clock);
        reset = rst_drv;
        if (stim_q.size() > 0 && $urandom_range(99, 0) < valid_pct) begin
            req_valid = 1'b1;
            {req_dividend, req_divisor} = stim_q[0];
        end else begin
            req_valid = 1'b0;
            req_dividend = $urandom;
            req_divisor = 16'($urandom);
        end
        res_ready = ($urandom_range(99, 0) < ready_pct);
        // divider: start -> (gap) -> busy for a few cycles -> ready level
        cap_now = 1'b0;
        if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
                div_busy = 1'b0;
                div_ready = 1'b1;
                {div_quotient, div_remainder} = ref_div(dv_op);
                cap_now = dv_owner && (phase == PH_WAIT);
                dv_owner = 1'b0;
            end else begin
                div_quotient = $urandom;
                div_remainder = 16'($urandom);
            end
        end else if (dv_delay > 0) begin
            dv_delay--;
            if (dv_delay == 0) begin
                div_busy = 1'b1;
                div_ready = 1'b0;
                dv_cnt = $urandom_range(lat_max, lat_min);
                div_quotient = $urandom;
                div_remainder = 16'($urandom);
            end
        end
        #1;
        s_rdy = req_ready;
        s_start = div_start;
        s_rv = res_valid;
        n_cmp++;
        if (pending !== (PTR_W + 1)'(fifo_m.size())) begin
            n_bad++;
            $display("FAIL pending: got %0d want %0d", pending, fifo_m.size());
        end
        exp_rdy = rst_drv && (fifo_m.size() != DEPTH);
        n_cmp++;
        if (s_rdy !== exp_rdy) begin
            n_bad++;
            $display("FAIL req_ready: got %b want %b", s_rdy, exp_rdy);
        end
        exp_start = 1'b0;
        exp_bypass = 1'b0;
        head = '0;
        if (rst_drv && phase == PH_IDLE && fifo_m.size() > 0) begin
            head = fifo_m[0];
`ifdef DIV0_BYPASS_EN
            if (head[15:0] == 16'd0) exp_bypass = 1'b1;
            else
`endif
            exp_start = !div_busy;
        end
        n_cmp++;
        if (s_start !== exp_start) begin
            n_bad++;
            $display("FAIL div_start: got %b want %b", s_start, exp_start);
        end
        opnd = {div_dividend, div_divisor};
        if (exp_start) begin
            n_cmp++;
            if (opnd !== head) begin
                n_bad++;
                $display("FAIL start_operands: got %h want %h", opnd, head);
            end
        end
        if (phase != PH_IDLE && fl_issued) begin
            n_cmp++;
            if (opnd !== fl_op) begin
                n_bad++;
                $display("FAIL held_operands: got %h want %h", opnd, fl_op);
            end
        end
        n_cmp++;
        if (s_rv !== (phase == PH_HOLD)) begin
            n_bad++;
            $display("FAIL res_valid: got %b want %b", s_rv, (phase == PH_HOLD));
        end
        res_now = {res_div0, res_quotient, res_remainder};
        res_exp = {exp_d0, exp_q, exp_r};
        if (phase == PH_HOLD) begin
            n_cmp++;
            if (res_now !== res_exp) begin
                n_bad++;
                $display("FAIL result: got %h want %h", res_now, res_exp);
            end
        end
        // reference model advances to the state after the coming posedge
        if (s_start) start_cnt++;
        if (!rst_drv) begin
            fifo_m.delete();
            phase = PH_IDLE;
            fl_issued = 1'b0;
            dv_owner = 1'b0;
        end else begin
            if (req_valid && s_rdy) begin
                fifo_m.push_back({req_dividend, req_divisor});
                void'(stim_q.pop_front());
            end
            if (phase == PH_HOLD && res_ready) begin
                log_q.push_back(res_exp);
                phase = PH_IDLE;
                fl_issued = 1'b0;
            end else if (cap_now) begin
                phase = PH_HOLD;
            end else if (exp_start) begin
                void'(fifo_m.pop_front());
                phase = PH_WAIT;
                fl_op = head;
                fl_issued = 1'b1;
                {exp_q, exp_r} = ref_div(head);
                exp_d0 = 1'b0;
            end else if (exp_bypass) begin
                void'(fifo_m.pop_front());
                phase = PH_HOLD;
                fl_issued = 1'b0;
                exp_q = 32'hFFFF_FFFF;
                exp_r = head[31:16];
                exp_d0 = 1'b1;
            end
            if (s_start) begin
                dv_op = opnd;
                dv_owner = 1'b1;
                dv_delay = ($urandom_range(99, 0) < gap_pct) ? 2 : 1;
            end
        end
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || fifo_m.size() > 0 || phase != PH_IDLE) && n < budget) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d cycles want < %0d", n, budget);
        end
    endtask

    task automatic test_reset();
        rst_drv = 1'b0;
        repeat (3) cycle();
        n_cmp++;
        if ({res_quotient, res_remainder, res_div0, div_dividend, div_divisor, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%h/%b/%h/%h/%b want all 0", res_quotient,
                     res_remainder, res_div0, div_dividend, div_divisor, req_ready);
        end
        rst_drv = 1'b1;
        cycle();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
    endtask

    task automatic test_single();
        int s0;
        log_q.delete();
        s0 = start_cnt;
        stim_q.push_back({32'h0002_0000, 16'hFFFF});
        run_drain(100);
        n_cmp++;
        if (start_cnt - s0 != 1) begin
            n_bad++;
            $display("FAIL single_starts: got %0d want 1", start_cnt - s0);
        end
        n_cmp++;
        if (log_q.size() != 1 || log_q[0] !== {1'b0, 32'h0000_0002, 16'h0002}) begin
            n_bad++;
            $display("FAIL single_result: got %0d results want q=2 r=2", log_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        log_q.delete();
        s0 = start_cnt;
        valid_pct = 100;
        ready_pct = 100;
        stim_q.push_back({32'd100, 16'd7});
        stim_q.push_back({32'd255, 16'd16});
        run_drain(100);
        n_cmp++;
        if (start_cnt - s0 != 2) begin
            n_bad++;
            $display("FAIL b2b_starts: got %0d want 2", start_cnt - s0);
        end
        n_cmp++;
        if (log_q.size() != 2 || log_q[0] !== {1'b0, 32'd14, 16'd2} ||
            log_q[1] !== {1'b0, 32'd15, 16'd15}) begin
            n_bad++;
            $display("FAIL b2b_results: got %0d results want (14,2),(15,15)", log_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] sent [$];
        logic [47:0] op;
        logic [47:0] rr;
        log_q.delete();
        ready_pct = 0;
        for (int i = 0; i < 6; i++) begin
            op = {$urandom, 16'($urandom_range(65535, 1))};
            sent.push_back(op);
            stim_q.push_back(op);
        end
        repeat (30) cycle();
        n_cmp++;
        if (pending !== 3'd4 || req_ready !== 1'b0 || stim_q.size() != 1) begin
            n_bad++;
            $display("FAIL full_fifo: got pending=%0d ready=%b left=%0d want 4/0/1",
                     pending, req_ready, stim_q.size());
        end
        ready_pct = 100;
        run_drain(300);
        n_cmp++;
        if (log_q.size() != 6) begin
            n_bad++;
            $display("FAIL drain_count: got %0d want 6", log_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                rr = ref_div(sent[i]);
                n_cmp++;
                if (log_q[i][47:0] !== rr) begin
                    n_bad++;
                    $display("FAIL drain_order[%0d]: got %h want %h", i, log_q[i][47:0], rr);
                end
            end
        end
    endtask

    task automatic test_div0();
        int s0;
        log_q.delete();
        s0 = start_cnt;
        stim_q.push_back({32'h0000_1234, 16'd0});
        run_drain(100);
`ifdef DIV0_BYPASS_EN
        n_cmp++;
        if (start_cnt != s0 || log_q.size() != 1 || log_q[0] !== {1'b1, 32'hFFFF_FFFF, 16'h1234}) begin
            n_bad++;
            $display("FAIL div0_bypass: got starts=%0d results=%0d want 0 starts, div0 result",
                     start_cnt - s0, log_q.size());
        end
`else
        n_cmp++;
        if (start_cnt - s0 != 1 || log_q.size() != 1 || log_q[0][48] !== 1'b0) begin
            n_bad++;
            $display("FAIL div0_issue: got starts=%0d results=%0d want 1 start, div0=0",
                     start_cnt - s0, log_q.size());
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        int n;
        lat_min = 8;
        lat_max = 10;
        stim_q.push_back({32'd5000, 16'd3});
        n = 0;
        while (phase != PH_WAIT && n < 20) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (phase != PH_WAIT) begin
            n_bad++;
            $display("FAIL reach_wait: got phase %0d want %0d", phase, PH_WAIT);
        end
        repeat (2) cycle();
        rst_drv = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if (res_valid !== 1'b0 || pending !== '0 || div_start !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got valid=%b pending=%0d start=%b want 0/0/0",
                     res_valid, pending, div_start);
        end
        rst_drv = 1'b1;
        repeat (15) cycle();
        n_cmp++;
        if (div_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL late_ready: got ready=%b valid=%b want 1/0", div_ready, res_valid);
        end
        lat_min = 1;
        lat_max = 4;
        stim_q.push_back({32'd77, 16'd5});
        run_drain(100);
    endtask

    task automatic test_random();
        logic [15:0] d;
        log_q.delete();
        valid_pct = 60;
        ready_pct = 50;
        lat_min = 1;
        lat_max = 6;
        gap_pct = 30;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3, 0))
                0:       d = 16'd0;
                1:       d = 16'($urandom_range(15, 1));
                default: d = 16'($urandom);
            endcase
            stim_q.push_back({$urandom, d});
        end
        run_drain(3000);
        n_cmp++;
        if (log_q.size() != 40) begin
            n_bad++;
            $display("FAIL random_count: got %0d want 40", log_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_div0();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
